// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if
//   Groups the CPU-side request/response handshake and the external memory
//   bus pins of mem_bus_ctrl into one bundle.
// Ports (signals)
//   req, we, addr, wdata     requester -> controller transfer request
//   rdata, ack, busy, wr_err controller -> requester completion/status
//   bus_addr                 registered external address
//   bus_data_in              shared data bus as driven by the ROM/RAM tristates
//   bus_data_out/_oe         write data toward the bus and its drive enable
//   rom_cs_, ram_cs_         active-low chip selects
//   oe_, we_                 active-low output-enable / write strobes
// Modports
//   slave  : the controller's view (mem_bus_ctrl)
//   master : the requester + memory model's view (drives request and bus_data_in)
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
  logic              wr_err;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data_in;
  logic [DATA_W-1:0] bus_data_out;
  logic              bus_data_oe;
  logic              rom_cs_;
  logic              ram_cs_;
  logic              oe_;
  logic              we_;

  modport slave (
    input  req, we, addr, wdata, bus_data_in,
    output rdata, ack, busy, wr_err, bus_addr, bus_data_out, bus_data_oe,
           rom_cs_, ram_cs_, oe_, we_
  );

  modport master (
    output req, we, addr, wdata, bus_data_in,
    input  rdata, ack, busy, wr_err, bus_addr, bus_data_out, bus_data_oe,
           rom_cs_, ram_cs_, oe_, we_
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   CPU-side external memory bus sequencer feeding the ROM/RAM tristate stages.
//   Accepts one read/write at a time, decodes ROM (addr < ROM_SIZE) vs RAM,
//   and walks SETUP -> STROBE (WAIT+1 cycles) -> HOLD with every bus output
//   registered. Read data is captured at the end of the strobe and returned
//   with a one-cycle ack in HOLD.
// Ports
//   clk   in  single rising-edge clock
//   rst_  in  asynchronous reset, active low
//   bus   mem_bus_ctrl_if.slave - request handshake plus external bus pins
module mem_bus_ctrl #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] ROM_SIZE = ADDR_W'('h8000),
  parameter int                WAIT_RD  = 2,
  parameter int                WAIT_WR  = 1
) (
  input  logic           clk,
  input  logic           rst_,
  mem_bus_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [3:0] WAIT_RD_CNT = 4'(WAIT_RD);
  localparam logic [3:0] WAIT_WR_CNT = 4'(WAIT_WR);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       xfer_we;
  logic       xfer_rom;
  logic       req_rom;

  // Decode of the address currently presented; only used on the accepting edge.
  assign req_rom = (bus.addr < ROM_SIZE);

  // Sequencer and all registered bus outputs. Each state computes the outputs
  // that the *next* state must show, so strobes change cleanly on clock edges.
  // A write aimed at ROM never lowers rom_cs_ or we_, but keeps full timing so
  // the requester still gets its ack (flagged with wr_err).
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      xfer_we          <= 1'b0;
      xfer_rom         <= 1'b0;
      bus.rdata        <= '0;
      bus.ack          <= 1'b0;
      bus.busy         <= 1'b0;
      bus.wr_err       <= 1'b0;
      bus.bus_addr     <= '0;
      bus.bus_data_out <= '0;
      bus.bus_data_oe  <= 1'b0;
      bus.rom_cs_      <= 1'b1;
      bus.ram_cs_      <= 1'b1;
      bus.oe_          <= 1'b1;
      bus.we_          <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            state        <= SETUP;
            xfer_we      <= bus.we;
            xfer_rom     <= req_rom;
            bus.bus_addr <= bus.addr;
            cnt          <= bus.we ? WAIT_WR_CNT : WAIT_RD_CNT;
            bus.busy     <= 1'b1;
            bus.rom_cs_  <= ~(req_rom & ~bus.we);
            bus.ram_cs_  <= req_rom;
            if (bus.we) begin
              bus.bus_data_oe  <= 1'b1;
              bus.bus_data_out <= bus.wdata;
            end
          end
        end
        SETUP: begin
          state <= STROBE;
          if (xfer_we)
            bus.we_ <= xfer_rom;
          else
            bus.oe_ <= 1'b0;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            state       <= HOLD;
            bus.rom_cs_ <= 1'b1;
            bus.ram_cs_ <= 1'b1;
            bus.oe_     <= 1'b1;
            bus.we_     <= 1'b1;
            bus.ack     <= 1'b1;
            bus.wr_err  <= xfer_we & xfer_rom;
            // This edge ends the last strobe cycle, so the memory is still driving.
            if (!xfer_we)
              bus.rdata <= bus.bus_data_in;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          state           <= IDLE;
          bus.ack         <= 1'b0;
          bus.wr_err      <= 1'b0;
          bus.bus_data_oe <= 1'b0;
          bus.busy        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl
//   Directed bench for mem_bus_ctrl with default parameters (WAIT_RD=2,
//   WAIT_WR=1, ROM below 16'h8000). Expected strobe patterns are written out
//   cycle by cycle as {rom_cs_, ram_cs_, oe_, we_, bus_data_oe, ack, wr_err, busy}.
module tb_mem_bus_ctrl;

  logic clk;
  logic rst_;
  int   vectors;
  int   miscompares;

  mem_bus_ctrl_if #(.ADDR_W(16), .DATA_W(8)) mbus ();

  mem_bus_ctrl #(
    .ADDR_W  (16),
    .DATA_W  (8),
    .ROM_SIZE(16'h8000),
    .WAIT_RD (2),
    .WAIT_WR (1)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (mbus.slave)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Bus-safety invariants checked on every falling edge outside reset:
  // no data drive while memory output is enabled, never both chip selects.
  always @(negedge clk) begin
    if (rst_) begin
      vectors++;
      assert (!((mbus.oe_ === 1'b0) && (mbus.bus_data_oe === 1'b1)) &&
              !((mbus.rom_cs_ === 1'b0) && (mbus.ram_cs_ === 1'b0)))
      else begin
        miscompares++;
        $error("[TB] FAIL bus_safety observed oe_=%b doe=%b rom_cs_=%b ram_cs_=%b required no overlap",
               mbus.oe_, mbus.bus_data_oe, mbus.rom_cs_, mbus.ram_cs_);
      end
    end
  end

  function automatic logic [7:0] strobes();
    return {mbus.rom_cs_, mbus.ram_cs_, mbus.oe_, mbus.we_,
            mbus.bus_data_oe, mbus.ack, mbus.wr_err, mbus.busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w,
                               input logic [15:0] a, input logic [7:0] d);
    mbus.req   = r;
    mbus.we    = w;
    mbus.addr  = a;
    mbus.wdata = d;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_        = 1'b0;
    mbus.bus_data_in = 8'hA5;
    applyStimulus(1'b1, 1'b0, 16'h0010, 8'h00);

    // 1: reset held with req=1 keeps everything idle.
    tick();
    tick();
    checkOutput("reset_strobes", {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_0_0_0_0});
    checkOutput("reset_rdata",   {8'h0, mbus.rdata}, 16'h0000);
    checkOutput("reset_addr",    mbus.bus_addr, 16'h0000);
    checkOutput("reset_dout",    {8'h0, mbus.bus_data_out}, 16'h0000);
    rst_ = 1'b1;

    // 2: ROM read at 0x0010; request changes while busy must be ignored.
    tick();
    checkOutput("rd_setup", {8'h0, strobes()}, {8'h0, 8'b0_1_1_1_0_0_0_1});
    checkOutput("rd_addr",  mbus.bus_addr, 16'h0010);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 8'hEE);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rd_strobe%0d", i), {8'h0, strobes()}, {8'h0, 8'b0_1_0_1_0_0_0_1});
    end
    checkOutput("rd_addr_held", mbus.bus_addr, 16'h0010);
    tick();
    checkOutput("rd_hold",  {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_0_1_0_1});
    checkOutput("rd_rdata", {8'h0, mbus.rdata}, 16'h00A5);
    mbus.bus_data_in = 8'h00;
    tick();
    checkOutput("rd_idle",       {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_0_0_0_0});
    checkOutput("rd_rdata_held", {8'h0, mbus.rdata}, 16'h00A5);

    // 3: RAM write 0x8004 <- 0x3C.
    applyStimulus(1'b1, 1'b1, 16'h8004, 8'h3C);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    checkOutput("wr_setup", {8'h0, strobes()}, {8'h0, 8'b1_0_1_1_1_0_0_1});
    checkOutput("wr_dout",  {8'h0, mbus.bus_data_out}, 16'h003C);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("wr_strobe%0d", i), {8'h0, strobes()}, {8'h0, 8'b1_0_1_0_1_0_0_1});
    end
    tick();
    checkOutput("wr_hold",      {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_1_1_0_1});
    checkOutput("wr_dout_hold", {8'h0, mbus.bus_data_out}, 16'h003C);
    tick();
    checkOutput("wr_idle", {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_0_0_0_0});

    // 4: write to ROM 0x0004 - no chip select, no we_, ack with wr_err.
    applyStimulus(1'b1, 1'b1, 16'h0004, 8'h55);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("romwr_c%0d", i + 1), {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_1_0_0_1});
      tick();
    end
    checkOutput("romwr_hold", {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_1_1_1_1});
    tick();
    checkOutput("romwr_idle", {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_0_0_0_0});

    // 5: back-to-back reads, RAM 0x8000 then ROM 0x7FFF with req held.
    mbus.bus_data_in = 8'h5A;
    applyStimulus(1'b1, 1'b0, 16'h8000, 8'h00);
    tick();
    checkOutput("b2b_setup1", {8'h0, strobes()}, {8'h0, 8'b1_0_1_1_0_0_0_1});
    checkOutput("b2b_addr1",  mbus.bus_addr, 16'h8000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("b2b_strobe1_%0d", i), {8'h0, strobes()}, {8'h0, 8'b1_0_0_1_0_0_0_1});
    end
    tick();
    checkOutput("b2b_ack1",   {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_0_1_0_1});
    checkOutput("b2b_rdata1", {8'h0, mbus.rdata}, 16'h005A);
    applyStimulus(1'b1, 1'b0, 16'h7FFF, 8'h00);
    mbus.bus_data_in = 8'hC3;
    tick();
    checkOutput("b2b_gap", {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_0_0_0_0});
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    checkOutput("b2b_setup2", {8'h0, strobes()}, {8'h0, 8'b0_1_1_1_0_0_0_1});
    checkOutput("b2b_addr2",  mbus.bus_addr, 16'h7FFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("b2b_strobe2_%0d", i), {8'h0, strobes()}, {8'h0, 8'b0_1_0_1_0_0_0_1});
    end
    tick();
    checkOutput("b2b_ack2",   {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_0_1_0_1});
    checkOutput("b2b_rdata2", {8'h0, mbus.rdata}, 16'h00C3);
    tick();
    checkOutput("b2b_idle", {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_0_0_0_0});

    // 6: asynchronous reset in the middle of a RAM write strobe.
    applyStimulus(1'b1, 1'b1, 16'h9000, 8'h77);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    checkOutput("rst_mid_strobe", {8'h0, strobes()}, {8'h0, 8'b1_0_1_0_1_0_0_1});
    #2;
    rst_ = 1'b0;
    #1;
    checkOutput("rst_async",      {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_0_0_0_0});
    checkOutput("rst_async_addr", mbus.bus_addr, 16'h0000);
    tick();
    rst_ = 1'b1;
    tick();
    tick();
    checkOutput("rst_no_ack", {8'h0, strobes()}, {8'h0, 8'b1_1_1_1_0_0_0_0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
